// File: rtl/sr_latch_arbiter.sv
// Round-robin arbiter that shares one SR latch among N_REQ requesters, issuing
// fixed-width s/r pulses separated by a guard cycle and tracking the latch value.
module sr_latch_arbiter #(
  parameter int N_REQ   = 4,
  parameter int PULSE_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] set_req,
  input  logic [N_REQ-1:0] clr_req,
  output logic             s,
  output logic             r,
  output logic [N_REQ-1:0] ack,
  output logic             busy,
  output logic             q_state,
  output logic             q_valid,
  output logic             conflict
);

  localparam int PTR_W = $clog2(N_REQ);
  localparam int CNT_W = $clog2(PULSE_W) + 1;
  localparam logic [PTR_W-1:0] LAST     = PTR_W'(N_REQ - 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(PULSE_W - 1);

  typedef enum logic [1:0] {IDLE, DRIVE, GAP} state_t;

  // Handshake: set_req/clr_req are levels held until ack; ack is a one-cycle
  // pulse and the request must be low by the edge that ends the ack cycle.
  state_t           state, state_n;
  logic [PTR_W-1:0] ptr, ptr_n, grant, grant_n, pick, idx, fin_g;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [N_REQ-1:0] pending, ack_n;
  logic             op_set, op_set_n, found, pick_set, finish, fin_op;
  logic             s_n, r_n, q_state_n, q_valid_n, conflict_n, busy_n;

  assign pending  = set_req | clr_req;
  assign pick_set = ~clr_req[pick];

  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = PTR_W'((int'(ptr) + i) % N_REQ);
      if (!found && pending[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  always_comb begin
    state_n    = state;
    ptr_n      = ptr;
    grant_n    = grant;
    cnt_n      = cnt;
    op_set_n   = op_set;
    s_n        = 1'b0;
    r_n        = 1'b0;
    ack_n      = '0;
    conflict_n = 1'b0;
    q_state_n  = q_state;
    q_valid_n  = q_valid;
    finish     = 1'b0;
    fin_g      = grant;
    fin_op     = op_set;
    case (state)
      IDLE: begin
        if (found) begin
          grant_n    = pick;
          op_set_n   = pick_set;
          conflict_n = set_req[pick] & clr_req[pick];
          // Latch already holds the requested value: complete without a pulse.
          if (q_valid && (q_state == pick_set)) begin
            finish = 1'b1;
            fin_g  = pick;
            fin_op = pick_set;
          end else begin
            state_n = DRIVE;
            cnt_n   = CNT_LOAD;
            s_n     = pick_set;
            r_n     = ~pick_set;
          end
        end
      end
      DRIVE: begin
        if (cnt == '0) begin
          finish = 1'b1;
        end else begin
          cnt_n = cnt - 1'b1;
          s_n   = op_set;
          r_n   = ~op_set;
        end
      end
      GAP:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (finish) begin
      state_n      = GAP;
      ack_n[fin_g] = 1'b1;
      q_state_n    = fin_op;
      q_valid_n    = 1'b1;
      ptr_n        = (fin_g == LAST) ? '0 : fin_g + 1'b1;
    end
    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= '0;
      grant    <= '0;
      cnt      <= '0;
      op_set   <= 1'b0;
      s        <= 1'b0;
      r        <= 1'b0;
      ack      <= '0;
      busy     <= 1'b0;
      q_state  <= 1'b0;
      q_valid  <= 1'b0;
      conflict <= 1'b0;
    end else begin
      state    <= state_n;
      ptr      <= ptr_n;
      grant    <= grant_n;
      cnt      <= cnt_n;
      op_set   <= op_set_n;
      s        <= s_n;
      r        <= r_n;
      ack      <= ack_n;
      busy     <= busy_n;
      q_state  <= q_state_n;
      q_valid  <= q_valid_n;
      conflict <= conflict_n;
    end
  end

endmodule

// File: tb/tb_sr_latch_arbiter.sv
// Bench for sr_latch_arbiter: directed and random request traffic checked every
// cycle against an operation-level schedule model, plus a reset-mid-pulse case.
module tb_sr_latch_arbiter;

  localparam int N_REQ   = 4;
  localparam int PULSE_W = 2;
  localparam int W       = N_REQ + 6;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst = 1'b1;
  logic [N_REQ-1:0] set_req = '0, clr_req = '0;
  logic             s, r, busy, q_state, q_valid, conflict;
  logic [N_REQ-1:0] ack;

  logic             rst4 = 1'b1;
  logic [N_REQ-1:0] set4 = '0, clr4 = '0;
  logic             s4, r4, busy4, q_state4, q_valid4, conflict4;
  logic [N_REQ-1:0] ack4;

  sr_latch_arbiter #(.N_REQ(N_REQ), .PULSE_W(PULSE_W)) dut (
    .clk(clk), .rst(rst), .set_req(set_req), .clr_req(clr_req),
    .s(s), .r(r), .ack(ack), .busy(busy), .q_state(q_state),
    .q_valid(q_valid), .conflict(conflict)
  );

  sr_latch_arbiter #(.N_REQ(N_REQ), .PULSE_W(4)) dut4 (
    .clk(clk), .rst(rst4), .set_req(set4), .clr_req(clr4),
    .s(s4), .r(r4), .ack(ack4), .busy(busy4), .q_state(q_state4),
    .q_valid(q_valid4), .conflict(conflict4)
  );

  // scoreboard: per-cycle expected output vectors {s,r,ack,busy,q_state,q_valid,conflict}
  logic [W-1:0] exp_q[$];
  logic [W-1:0] cur = '0;
  logic [W-1:0] obs;
  int           m_ptr = 0;
  logic         m_q = 1'b0, m_qv = 1'b0;
  logic         prev_s = 1'b0, prev_r = 1'b0;
  int           checks = 0, passes = 0;
  int           ack_log[$];

  function automatic logic [W-1:0] mk(input logic vs, input logic vr, input logic [N_REQ-1:0] va,
                                      input logic vb, input logic vq, input logic vqv, input logic vc);
    return {vs, vr, va, vb, vq, vqv, vc};
  endfunction

  function automatic logic [N_REQ-1:0] v_ack(input logic [W-1:0] v);
    return v[4 +: N_REQ];
  endfunction

  task automatic check(input string tag, input logic [W-1:0] o, input logic [W-1:0] e);
    checks++;
    assert (o === e) passes++;
    else $error("FAIL %s observed=%h expected=%h", tag, o, e);
  endtask

  // One grant: pick the first pending index from the pointer, then lay out the
  // whole operation (pulse cycles then ack cycle) as a list of output vectors.
  task automatic schedule();
    logic [N_REQ-1:0] pend;
    int   g;
    logic op, conf, redundant;
    pend = set_req | clr_req;
    if (pend == '0) return;
    g = -1;
    for (int i = 0; i < N_REQ; i++)
      if (g < 0 && pend[(m_ptr + i) % N_REQ]) g = (m_ptr + i) % N_REQ;
    op        = !clr_req[g];
    conf      = set_req[g] && clr_req[g];
    redundant = m_qv && (m_q == op);
    if (!redundant)
      for (int p = 0; p < PULSE_W; p++)
        exp_q.push_back(mk(op, !op, '0, 1'b1, m_q, m_qv, conf && (p == 0)));
    exp_q.push_back(mk(1'b0, 1'b0, N_REQ'(1) << g, 1'b1, op, 1'b1, conf && redundant));
    m_q   = op;
    m_qv  = 1'b1;
    m_ptr = (g + 1) % N_REQ;
  endtask

  always @(posedge clk) begin
    if (rst) begin
      exp_q.delete();
      cur   = '0;
      m_ptr = 0;
      m_q   = 1'b0;
      m_qv  = 1'b0;
    end else begin
      if (!cur[3]) schedule();
      if (exp_q.size() > 0) cur = exp_q.pop_front();
      else cur = mk(1'b0, 1'b0, '0, 1'b0, m_q, m_qv, 1'b0);
    end
    #1;
    obs = {s, r, ack, busy, q_state, q_valid, conflict};
    check("cycle", obs, cur);
    check("s_and_r", W'(s & r), '0);
    check("pulse_spacing", W'((prev_s & r) | (prev_r & s)), '0);
    prev_s = s;
    prev_r = r;
  end

  // driver tasks (called just after a falling edge)
  task automatic run_req(input logic [N_REQ-1:0] sb, input logic [N_REQ-1:0] cb, input int budget);
    logic [N_REQ-1:0] a;
    int n;
    n = 0;
    set_req = sb;
    clr_req = cb;
    while (((set_req | clr_req) != '0) && n < budget) begin
      @(negedge clk);
      n++;
      for (int i = 0; i < N_REQ; i++) if (ack[i]) ack_log.push_back(i);
      a = v_ack(cur);
      set_req = set_req & ~a;
      clr_req = clr_req & ~a;
    end
    check("req_timeout", W'(set_req | clr_req), '0);
    set_req = '0;
    clr_req = '0;
    repeat (2) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    logic [N_REQ-1:0] a;
    // reset then single set
    repeat (2) @(negedge clk);
    rst  = 1'b0;
    rst4 = 1'b0;
    @(negedge clk);
    run_req(4'b0001, 4'b0000, 20);
    check("single_set_q", W'({q_state, q_valid}), W'(2'b11));
    // redundant set from requester 2
    run_req(4'b0100, 4'b0000, 20);
    check("redundant_q", W'({q_state, q_valid}), W'(2'b11));
    // round-robin clears from pointer 0
    do_reset();
    ack_log.delete();
    run_req(4'b0000, 4'b1111, 40);
    check("rr_count", W'(ack_log.size()), W'(4));
    for (int i = 0; i < 4; i++)
      check("rr_order", W'((i < ack_log.size()) ? ack_log[i] : -1), W'(i));
    // conflict on requester 1 after latch set by requester 0
    run_req(4'b0001, 4'b0000, 20);
    run_req(4'b0010, 4'b0010, 20);
    check("conflict_q", W'({q_state, q_valid}), W'(2'b01));

    // reset during the second pulse cycle of a PULSE_W=4 clear
    clr4 = 4'b0001;
    @(negedge clk);
    check("p4_r_cyc1", W'({s4, r4}), W'(2'b01));
    @(negedge clk);
    check("p4_r_cyc2", W'({s4, r4}), W'(2'b01));
    rst4 = 1'b1;
    clr4 = '0;
    @(negedge clk);
    check("p4_abort", W'({s4, r4, ack4, busy4, q_valid4, q_state4, conflict4}), '0);
    rst4 = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check("p4_no_ack", W'({ack4, busy4, r4}), '0);
    end

    // random traffic with occasional resets
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 199) == 0);
      a = v_ack(cur);
      for (int i = 0; i < N_REQ; i++) begin
        if ((set_req[i] | clr_req[i]) && a[i]) begin
          set_req[i] = 1'b0;
          clr_req[i] = 1'b0;
        end else if (!(set_req[i] | clr_req[i]) && $urandom_range(0, 3) == 0) begin
          case ($urandom_range(0, 7))
            0:       begin set_req[i] = 1'b1; clr_req[i] = 1'b1; end
            1, 2, 3: set_req[i] = 1'b1;
            default: clr_req[i] = 1'b1;
          endcase
        end
      end
    end
    rst = 1'b0;
    set_req = '0;
    clr_req = '0;
    repeat (10) @(negedge clk);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/sr_latch_arbiter.md
# sr_latch_arbiter

Clocked controller that shares one SR latch (`srlatch`) among `N_REQ` requesters. Each requester asks to set or clear the latch. The arbiter grants requesters round-robin and drives the latch `s`/`r` inputs with fixed-width pulses, with a guard cycle between operations. It never presents `s=r=1` to the latch and tracks the latch state so redundant operations complete without a pulse. It sits between the flag-owning agents and the `srlatch` instance.

## Interface
- `N_REQ`, 4, number of requesters (≥2).
- `PULSE_W`, 2, cycles `s` or `r` is held high per operation (≥1).

Ports:
- `clk`  input  1  rising-edge clock.
- `rst`  input  1  synchronous, active-high reset.
- `set_req`  input  N_REQ  per-requester set request, level; held until ack.
- `clr_req`  input  N_REQ  per-requester clear request, level; held until ack.
- `s`  output  1  latch set drive, registered.
- `r`  output  1  latch reset drive, registered.
- `ack`  output  N_REQ  one-cycle completion pulse, one-hot or zero.
- `busy`  output  1  high in any state other than IDLE.
- `q_state`  output  1  tracked latch value.
- `q_valid`  output  1  `q_state` is known.
- `conflict`  output  1  one-cycle pulse: the granted requester had both `set_req` and `clr_req` high.

## Operation
- **States:** IDLE, DRIVE, GAP.
- **Reset:** all outputs are 0. State is IDLE. The round-robin pointer is 0. The pulse counter is 0.
- **IDLE:**
  - A requester is pending when `set_req[i] | clr_req[i]`.
  - If none is pending, stay in IDLE.
  - Otherwise grant the first pending index at or after the pointer, wrapping modulo `N_REQ`.
- **Operation select for grant g:**
  - `clr_req[g]` high selects clear. Clear wins when both are high, and `conflict` pulses on the grant edge.
  - Otherwise the operation is set.
- **Redundant operation:** when `q_valid=1` and the operation equals `q_state`, go directly to GAP. No `s`/`r` pulse is issued.
- **Non-redundant operation:**
  - Go to DRIVE and load the counter with `PULSE_W-1`.
  - Register `s=1` for set or `r=1` for clear.
- **DRIVE:**
  - Hold the selected drive.
  - Decrement the counter. At 0, deassert `s`/`r` and go to GAP.
- **GAP (one cycle):**
  - `s=r=0` and `ack[g]=1`.
  - `q_state` takes the operation value and `q_valid` is set.
  - The pointer becomes `(g+1) mod N_REQ`.
  - Go to IDLE.
- **Invariant:** `s & r` is never 1 on any cycle, including reset.
- **Request rules:** requests are sampled only in IDLE. Changes to a granted request during DRIVE/GAP are ignored. The requester must drop its request by the edge after `ack`.
- **Width rules:** the counter is `$clog2(PULSE_W)+1` bits. The pointer is `$clog2(N_REQ)` bits and wraps from `N_REQ-1` to 0.

## Timing
- **Grant:** a request is sampled in IDLE at edge k.
  - Non-redundant: `s`/`r` are high for cycles k+1 … k+PULSE_W. `ack` is high on cycle k+PULSE_W+1.
  - Redundant: `ack` is high on cycle k+1.
- **Back-to-back:** the next grant edge is at the earliest k+PULSE_W+2. At least one cycle of `s=r=0` separates consecutive pulses.
- **`busy`:** high from cycle k+1 through the `ack` cycle inclusive.
- **Reset asserted mid-operation:**
  - On the next edge, `s`, `r`, `ack`, `busy`, `q_state`, `q_valid` and `conflict` go to 0 and the state goes to IDLE.
  - No `ack` is issued for the aborted operation.
  - The pointer returns to 0.
- **Simultaneous requests:** one grant per operation. Losers wait; their requests stay pending.
- **Starvation bound:** a continuously asserted request is acked within `N_REQ` operations.

## Test plan
- **Reset then single set:** reset, then `set_req=4'b0001` at edge k → `s=1` on cycles k+1, k+2; `r=0` throughout; `ack=4'b0001` on k+3; `q_state=1`, `q_valid=1` after k+3.
- **Redundant set:** with `q_state=1`, `q_valid=1`, assert `set_req[2]` → no `s` pulse; `ack=4'b0100` on the next cycle; `q_state` stays 1.
- **Round-robin:** `clr_req=4'b1111` held, each bit dropped after its ack, pointer 0 → acks in order 0, 1, 2, 3. Requester 0 gets one `r` pulse because `q_valid=0` or `q_state=1`. Requesters 1–3 are redundant and ack with no pulse. Only one `ack` bit is high at a time.
- **Conflict:** `set_req[1]=clr_req[1]=1` → `conflict` pulses for one cycle; `r` pulses, never `s`; `q_state=0` after ack.
- **Reset mid-DRIVE (PULSE_W=4):** assert `rst` on the 2nd pulse cycle → `r=0` on the next cycle; no `ack`; `q_valid=0`; `busy=0`.
- **Invariant and spacing checker:** over random request traffic, `s&r` is never 1, and at least one idle cycle separates successive pulses.
